// File: rtl/cmd_encap_pkg.sv
// Shared HCP command layout, type code and module-id constants for the command encapsulator.
package cmd_encap_pkg;

  localparam int unsigned CMD_W        = 64;
  localparam int unsigned PAYLOAD_W    = 51;
  localparam int unsigned MID_W        = 7;
  localparam int unsigned SEQ_W        = 3;

  localparam int unsigned CMD_DATA_LSB = 0;
  localparam int unsigned CMD_ADDR_LSB = 32;
  localparam int unsigned CMD_MID_LSB  = 51;
  localparam int unsigned CMD_SEQ_LSB  = 58;
  localparam int unsigned CMD_FIX_BIT  = 61;
  localparam int unsigned CMD_TYPE_LSB = 62;

  localparam logic [1:0] CMD_TYPE_RD = 2'b11;

  localparam logic [MID_W-1:0] MID_HRG = 7'd0;
  localparam logic [MID_W-1:0] MID_OST = 7'd1;
  localparam logic [MID_W-1:0] MID_CC  = 7'd2;
  localparam logic [MID_W-1:0] MID_TFT = 7'd3;
  localparam logic [MID_W-1:0] MID_OSM = 7'd4;

  typedef struct packed {
    logic [1:0]           cmd_type;
    logic                 fix;
    logic [SEQ_W-1:0]     seq;
    logic [MID_W-1:0]     mid;
    logic [PAYLOAD_W-1:0] payload;  // {raddr, rdata}
  } cmd_t;

endpackage

// File: rtl/cmd_ch_fifo.sv
// Per-channel FIFO; an empty FIFO passes the incoming write straight to the read port so a
// same-cycle push/pop costs no latency.
module cmd_ch_fifo #(
  parameter int unsigned W     = 52,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] iv_wdata,
  output logic [W-1:0] ov_rdata_c,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cmd_ch_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_nxt;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok    = i_push & ~o_full;
    pop_ok     = i_pop & (~o_empty | push_ok);
    count_nxt  = count_q + CW'(push_ok) - CW'(pop_ok);
    ov_rdata_c = o_empty ? iv_wdata : mem[rptr_q];
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr_q] <= iv_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_nxt;
      o_full  <= (count_nxt == CW'(DEPTH));
      o_empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/command_encapsulate_rr_arb.sv
// Round-robin command encapsulator: per-channel FIFOs feed one registered ready/valid HCP port.
// Optional CMD_ENCAP_SEQ_EN stamps a 3-bit wrapping sequence number into each command.
module command_encapsulate_rr_arb
  import cmd_encap_pkg::*;
#(
  parameter int unsigned CH_NUM     = 5,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MID_BASE   = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [CH_NUM-1:0]        iv_wr,
  input  logic [CH_NUM*ADDR_W-1:0] iv_raddr,
  input  logic [CH_NUM-1:0]        iv_addr_fix,
  input  logic [CH_NUM*DATA_W-1:0] iv_rdata,
  output logic [CH_NUM-1:0]        ov_full,
  output logic [63:0]              ov_command,
  output logic                     o_command_wr,
  input  logic                     i_command_ready,
  output logic [15:0]              ov_drop_cnt
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W + 1;
  localparam int unsigned PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  if (ADDR_W + DATA_W != PAYLOAD_W) begin : g_bad_width
    $error("command_encapsulate_rr_arb: ADDR_W + DATA_W must equal 51");
  end
  if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
    $error("command_encapsulate_rr_arb: CH_NUM must be 1..8");
  end
  if (CMD_DATA_LSB != 0 || CMD_MID_LSB != PAYLOAD_W || CMD_SEQ_LSB != CMD_MID_LSB + MID_W ||
      CMD_FIX_BIT != CMD_SEQ_LSB + SEQ_W || CMD_TYPE_LSB != CMD_FIX_BIT + 1 ||
      CMD_TYPE_LSB + 2 != CMD_W || CMD_ADDR_LSB > CMD_MID_LSB) begin : g_bad_layout
    $error("command_encapsulate_rr_arb: inconsistent command field layout");
  end

  logic [CH_NUM-1:0] fifo_full, fifo_empty, push, pop, req, drops;
  logic [ENT_W-1:0]  fifo_rd [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    cmd_ch_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (push[g]),
      .i_pop      (pop[g]),
      .iv_wdata   ({iv_addr_fix[g], iv_raddr[g*ADDR_W +: ADDR_W], iv_rdata[g*DATA_W +: DATA_W]}),
      .ov_rdata_c (fifo_rd[g]),
      .o_full     (fifo_full[g]),
      .o_empty    (fifo_empty[g])
    );
  end

  logic [PTR_W-1:0]  ptr_q, gnt_idx;
  logic              gnt_vld, load;
  logic [ENT_W-1:0]  sel;
  logic [SEQ_W-1:0]  seq_cur;
  logic [3:0]        ndrop;
  logic [16:0]       drop_sum;
  logic [15:0]       drop_q, drop_nxt;
  logic [63:0]       cmd_q;
  logic              wr_q;
  int unsigned       idx;
  cmd_t              cmd_nxt;

  // Requests include writes landing this cycle so an idle block forwards them immediately.
  always_comb begin
    push  = iv_wr & ~fifo_full;
    drops = iv_wr & fifo_full;
    req   = ~fifo_empty | push;
    ndrop = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) ndrop = ndrop + 4'(drops[k]);
    drop_sum = 17'(drop_q) + 17'(ndrop);
    drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    load = (~wr_q | i_command_ready) & gnt_vld;
    pop  = load ? (CH_NUM'(1) << gnt_idx) : '0;
    sel  = fifo_rd[gnt_idx];
    cmd_nxt.cmd_type = CMD_TYPE_RD;
    cmd_nxt.fix      = sel[ENT_W-1];
    cmd_nxt.seq      = seq_cur;
    cmd_nxt.mid      = MID_W'(MID_BASE + 32'(gnt_idx));
    cmd_nxt.payload  = sel[PAYLOAD_W-1:0];
  end

`ifdef CMD_ENCAP_SEQ_EN
  logic [SEQ_W-1:0] seq_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  seq_q <= '0;
    else if (load) seq_q <= seq_q + SEQ_W'(1);
  end
  assign seq_cur = seq_q;
`else
  assign seq_cur = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q  <= '0;
      cmd_q  <= '0;
      wr_q   <= 1'b0;
      drop_q <= '0;
    end else begin
      drop_q <= drop_nxt;
      if (load) begin
        cmd_q <= cmd_nxt;
        wr_q  <= 1'b1;
        ptr_q <= (32'(gnt_idx) == CH_NUM - 1) ? '0 : gnt_idx + PTR_W'(1);
      end else if (wr_q && i_command_ready) begin
        cmd_q <= '0;
        wr_q  <= 1'b0;
      end
    end
  end

  assign ov_command   = cmd_q;
  assign o_command_wr = wr_q;
  assign ov_drop_cnt  = drop_q;
  assign ov_full      = fifo_full;

endmodule

// File: tb/tb_command_encapsulate_rr_arb.sv
// Directed bench for command_encapsulate_rr_arb: vector table plus hand-written corner sequences.
module tb_command_encapsulate_rr_arb;

  localparam int unsigned CH = 5;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 32;
  localparam logic [63:0] SEQ_MASK = 64'h1C00_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    wr;
  logic [CH*AW-1:0] raddr;
  logic [CH-1:0]    fix;
  logic [CH*DW-1:0] rdata;
  logic [CH-1:0]    full;
  logic [63:0]      cmd;
  logic             cmd_wr;
  logic             ready;
  logic [15:0]      drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  command_encapsulate_rr_arb #(
    .CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .MID_BASE(0)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .iv_wr           (wr),
    .iv_raddr        (raddr),
    .iv_addr_fix     (fix),
    .iv_rdata        (rdata),
    .ov_full         (full),
    .ov_command      (cmd),
    .o_command_wr    (cmd_wr),
    .i_command_ready (ready),
    .ov_drop_cnt     (drop)
  );

  typedef struct {
    logic [CH-1:0] wr;
    logic [18:0]   a_base;
    logic [31:0]   d_base;
    logic          fix;
    logic          rdy;
    logic          exp_wr;
    logic [63:0]   exp_cmd;
  } vec_t;

  function automatic logic [63:0] mk(int k, logic [18:0] a, logic [31:0] d, logic f, logic [2:0] s);
    return {2'b11, f, s, 7'(k), a, d};
  endfunction

  function automatic logic [2:0] exp_seq(int n);
`ifdef CMD_ENCAP_SEQ_EN
    return 3'(n % 8);
`else
    return 3'(n * 0);
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Channel k gets address a_base+k and data d_base+k.
  task automatic drive(logic [CH-1:0] m, logic [18:0] ab, logic [31:0] db, logic f, logic r);
    wr    = m;
    ready = r;
    for (int k = 0; k < int'(CH); k++) begin
      raddr[k*AW +: AW] = ab + 19'(k);
      rdata[k*DW +: DW] = db + 32'(k);
      fix[k]            = f;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  vec_t vecs[19];

  initial begin
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_cmd",  cmd, 64'd0);
    chk("rst_wr",   64'(cmd_wr), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    rst_n = 1'b1;

    // single, rotating burst from pointer 1, then two aligned bursts from pointer 0
    vecs[0] = '{5'b00001, 19'h00010, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 64'hE000_0010_DEAD_BEEF};
    vecs[1] = '{5'b00000, 19'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0};
    for (int j = 0; j < 4; j++)
      vecs[2+j] = '{(j == 0) ? 5'b11110 : 5'b0, 19'h50, 32'h500, 1'b1, 1'b1, 1'b1,
                    mk(j + 1, 19'h50 + 19'(j + 1), 32'h500 + 32'(j + 1), 1'b1, 3'd0)};
    vecs[6] = '{5'b00000, 19'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0};
    for (int j = 0; j < 5; j++) begin
      vecs[7+j]  = '{(j == 0) ? 5'b11111 : 5'b0, 19'h100, 32'h1000, 1'b0, 1'b1, 1'b1,
                     mk(j, 19'h100 + 19'(j), 32'h1000 + 32'(j), 1'b0, 3'd0)};
      vecs[13+j] = '{(j == 0) ? 5'b11111 : 5'b0, 19'h200, 32'h2000, 1'b1, 1'b1, 1'b1,
                     mk(j, 19'h200 + 19'(j), 32'h2000 + 32'(j), 1'b1, 3'd0)};
    end
    vecs[12] = '{5'b00000, 19'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[18] = '{5'b00000, 19'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].wr, vecs[i].a_base, vecs[i].d_base, vecs[i].fix, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_wr", i), 64'(cmd_wr), 64'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_cmd", i), cmd & ~SEQ_MASK, vecs[i].exp_cmd);
      chk($sformatf("vec%0d_full", i), 64'(full), 64'd0);
    end
    chk("vec_drop", 64'(drop), 64'd0);

    // backpressure: ch3 held for 10 cycles, second ch3 entry follows without a bubble
    pulse_reset();
    drive(5'b01000, 19'h300, 32'h3000, 1'b0, 1'b0);
    step();
    chk("bp_load", cmd, mk(3, 19'h303, 32'h3003, 1'b0, 3'd0));
    drive(5'b01000, 19'h310, 32'h3010, 1'b0, 1'b0);
    step();
    drive('0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), {cmd[63:1], cmd_wr}, {mk(3, 19'h303, 32'h3003, 1'b0, 3'd0) >> 1, 1'b1});
    end
    ready = 1'b1;
    step();
    chk("bp_next_wr", 64'(cmd_wr), 64'd1);
    chk("bp_next",    cmd, mk(3, 19'h313, 32'h3013, 1'b0, exp_seq(1)));
    step();
    chk("bp_idle_wr",  64'(cmd_wr), 64'd0);
    chk("bp_idle_cmd", cmd, 64'd0);

    // overflow: six writes to ch1 with the output stalled
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(5'b00010, 19'h400 + 19'(i), 32'h4000 + 32'(i), 1'b1, 1'b0);
      step();
      chk($sformatf("ovf_full%0d", i), 64'(full), (i >= 4) ? 64'h2 : 64'h0);
      chk($sformatf("ovf_drop%0d", i), 64'(drop), (i == 5) ? 64'd1 : 64'd0);
    end
    chk("ovf_held", cmd, mk(1, 19'h401, 32'h4001, 1'b1, 3'd0));
    drive('0, '0, '0, 1'b0, 1'b1);
    for (int j = 1; j < 5; j++) begin
      step();
      chk($sformatf("ovf_drain%0d", j), cmd, mk(1, 19'h401 + 19'(j), 32'h4001 + 32'(j), 1'b1, exp_seq(j)));
      if (j == 1) chk("ovf_unfull", 64'(full), 64'd0);
    end
    step();
    chk("ovf_empty_wr", 64'(cmd_wr), 64'd0);
    chk("ovf_drop_hold", 64'(drop), 64'd1);

    // asynchronous reset with commands queued
    drive(5'b11111, 19'h500, 32'h5000, 1'b0, 1'b0);
    step();
    drive('0, '0, '0, 1'b0, 1'b1);
    chk("rmid_pre_wr", 64'(cmd_wr), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid_cmd",  cmd, 64'd0);
    chk("rmid_wr",   64'(cmd_wr), 64'd0);
    chk("rmid_drop", 64'(drop), 64'd0);
    chk("rmid_full", 64'(full), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rmid_post%0d", i), {cmd, 63'd0, cmd_wr} >> 63, 64'd0);
    end

    // sequence field over nine consecutive commands
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(5'b00100, 19'h600 + 19'(i), 32'h6000 + 32'(i), 1'b0, 1'b1);
      step();
      chk($sformatf("seq%0d", i), cmd, mk(2, 19'h602 + 19'(i), 32'h6002 + 32'(i), 1'b0, exp_seq(i)));
    end
    drive('0, '0, '0, 1'b0, 1'b1);
    step();
    chk("seq_end_wr", 64'(cmd_wr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
